// File: rtl/cache_port_arbiter_if.sv
// rtl/cache_port_arbiter_if.sv - CPU-side cache mem_itf port bundle
interface cache_port_arbiter_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  // Requester side: issues the request, receives read data and response
  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp
  );

  // Responder side: accepts the request, returns read data and response
  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// rtl/cache_port_arbiter.sv - two-port arbiter in front of a single cache mem_itf port
module cache_port_arbiter #(
  parameter int PRIO_MODE   = 0,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cache_port_arbiter_if.slave   p0,
  cache_port_arbiter_if.slave   p1,
  cache_port_arbiter_if.master  c,
  output logic [1:0]            grant,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, DONE} state_t;

  localparam logic [15:0] TIMEOUT_16 = 16'(TIMEOUT_CYC);
  localparam logic        PRIO_HI    = (PRIO_MODE != 0);

  state_t      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mbe_q,   mbe_d;
  logic        rd_q,    rd_d;
  logic        wr_q,    wr_d;
  logic        last_q,  last_d;
  logic [15:0] cnt_q,   cnt_d;
  logic        tout_q,  tout_d;

  logic        req0, req1, pick1;
  logic [31:0] win_addr, win_wdata;
  logic [3:0]  win_mbe;
  logic        win_rd, win_wr;

  // last_q holds the index of the port served last; a tie goes to the other one
  assign req0  = p0.mem_read | p0.mem_write;
  assign req1  = p1.mem_read | p1.mem_write;
  assign pick1 = req1 & (~req0 | PRIO_HI | ~last_q);

  assign win_addr  = pick1 ? p1.mem_address     : p0.mem_address;
  assign win_wdata = pick1 ? p1.mem_wdata       : p0.mem_wdata;
  assign win_mbe   = pick1 ? p1.mem_byte_enable : p0.mem_byte_enable;
  assign win_wr    = pick1 ? p1.mem_write       : p0.mem_write;
  // A requester asserting both strobes is treated as a write
  assign win_rd    = (pick1 ? p1.mem_read : p0.mem_read) & ~win_wr;

  // State and latched cache request; reset abandons any in-flight transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mbe_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mbe_q   <= mbe_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
    end
  end

  // Next-state: arbitration in IDLE, hold while granted, one bubble after resp
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mbe_d   = mbe_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tout_d  = tout_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = pick1 ? GNT1 : GNT0;
          addr_d  = win_addr;
          wdata_d = win_wdata;
          mbe_d   = win_mbe;
          rd_d    = win_rd;
          wr_d    = win_wr;
          cnt_d   = '0;
        end
      end
      GNT0, GNT1: begin
        if (c.mem_resp) begin
          state_d = DONE;
          addr_d  = '0;
          wdata_d = '0;
          mbe_d   = '0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          last_d  = (state_q == GNT1);
        end else if (cnt_q != 16'hffff) begin
          cnt_d = cnt_q + 16'd1;
        end
        // The watchdog only flags; the transaction keeps waiting for the cache
        if ((TIMEOUT_16 != 16'd0) && (cnt_d == TIMEOUT_16)) begin
          tout_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign c.mem_address     = addr_q;
  assign c.mem_wdata       = wdata_q;
  assign c.mem_byte_enable = mbe_q;
  assign c.mem_read        = rd_q;
  assign c.mem_write       = wr_q;

  assign grant       = {state_q == GNT1, state_q == GNT0};
  assign timeout_err = tout_q;

  // Responses are steered combinationally; a stray resp outside GNT reaches nobody
  assign p0.mem_resp  = c.mem_resp & grant[0];
  assign p1.mem_resp  = c.mem_resp & grant[1];
  assign p0.mem_rdata = c.mem_rdata;
  assign p1.mem_rdata = c.mem_rdata;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb/tb_cache_port_arbiter.sv - directed self-checking bench for cache_port_arbiter
module tb_cache_port_arbiter;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  cache_port_arbiter_if a_p0 ();
  cache_port_arbiter_if a_p1 ();
  cache_port_arbiter_if a_c ();
  cache_port_arbiter_if b_p0 ();
  cache_port_arbiter_if b_p1 ();
  cache_port_arbiter_if b_c ();
  logic [1:0] a_grant, b_grant;
  logic       a_tout, b_tout;

  // Round-robin instance with an 8-cycle watchdog
  cache_port_arbiter #(.PRIO_MODE(0), .TIMEOUT_CYC(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .p0(a_p0), .p1(a_p1), .c(a_c),
    .grant(a_grant), .timeout_err(a_tout)
  );

  // Fixed-priority instance, watchdog disabled
  cache_port_arbiter #(.PRIO_MODE(1), .TIMEOUT_CYC(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .p0(b_p0), .p1(b_p1), .c(b_c),
    .grant(b_grant), .timeout_err(b_tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_p0.mem_address = '0; a_p0.mem_read = 0; a_p0.mem_write = 0; a_p0.mem_byte_enable = '0; a_p0.mem_wdata = '0;
    a_p1.mem_address = '0; a_p1.mem_read = 0; a_p1.mem_write = 0; a_p1.mem_byte_enable = '0; a_p1.mem_wdata = '0;
    b_p0.mem_address = '0; b_p0.mem_read = 0; b_p0.mem_write = 0; b_p0.mem_byte_enable = '0; b_p0.mem_wdata = '0;
    b_p1.mem_address = '0; b_p1.mem_read = 0; b_p1.mem_write = 0; b_p1.mem_byte_enable = '0; b_p1.mem_wdata = '0;
    a_c.mem_rdata = '0; a_c.mem_resp = 0;
    b_c.mem_rdata = '0; b_c.mem_resp = 0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    clear_inputs();
    #3;
    chk("rst_c_read",  32'(a_c.mem_read), 32'd0);
    chk("rst_c_write", 32'(a_c.mem_write), 32'd0);
    chk("rst_c_addr",  a_c.mem_address, 32'h0);
    chk("rst_grant",   32'(a_grant), 32'd0);
    chk("rst_tout",    32'(a_tout), 32'd0);
    #9 rst_n = 1'b1;

    // Tie right after reset: p0 read first, then p1 write
    a_p0.mem_read = 1; a_p0.mem_address = 32'h100;
    a_p1.mem_write = 1; a_p1.mem_address = 32'h200; a_p1.mem_wdata = 32'haabbccdd; a_p1.mem_byte_enable = 4'b1100;
    tick();
    chk("t2_grant0", 32'(a_grant), 32'd1);
    chk("t2_addr0",  a_c.mem_address, 32'h100);
    chk("t2_read0",  32'(a_c.mem_read), 32'd1);
    chk("t2_write0", 32'(a_c.mem_write), 32'd0);
    a_c.mem_resp = 1; #1;
    chk("t2_p0resp", 32'(a_p0.mem_resp), 32'd1);
    chk("t2_p1resp", 32'(a_p1.mem_resp), 32'd0);
    tick();
    a_c.mem_resp = 0; a_p0.mem_read = 0;
    chk("t2_done_grant", 32'(a_grant), 32'd0);
    chk("t2_done_write", 32'(a_c.mem_write), 32'd0);
    chk("t2_done_addr",  a_c.mem_address, 32'h0);
    tick();
    chk("t2_idle_grant", 32'(a_grant), 32'd0);
    tick();
    chk("t2_grant1", 32'(a_grant), 32'd2);
    chk("t2_write1", 32'(a_c.mem_write), 32'd1);
    chk("t2_read1",  32'(a_c.mem_read), 32'd0);
    chk("t2_addr1",  a_c.mem_address, 32'h200);
    chk("t2_wdata1", a_c.mem_wdata, 32'haabbccdd);
    chk("t2_mbe1",   32'(a_c.mem_byte_enable), 32'hc);
    a_c.mem_resp = 1; #1;
    chk("t2_p1resp_b", 32'(a_p1.mem_resp), 32'd1);
    tick();
    a_c.mem_resp = 0; a_p1.mem_write = 0;
    a_p0.mem_read = 1; a_p0.mem_address = 32'h300;
    a_p1.mem_read = 1; a_p1.mem_address = 32'h400;
    tick();
    tick();
    chk("t2_tie2_grant", 32'(a_grant), 32'd1);
    chk("t2_tie2_addr",  a_c.mem_address, 32'h300);
    a_c.mem_resp = 1;
    tick();
    a_c.mem_resp = 0; a_p0.mem_read = 0; a_p1.mem_read = 0;
    tick();

    // Single read on p0 with data returned
    a_p0.mem_read = 1; a_p0.mem_address = 32'h1234;
    tick();
    chk("t1_read",  32'(a_c.mem_read), 32'd1);
    chk("t1_addr",  a_c.mem_address, 32'h1234);
    chk("t1_grant", 32'(a_grant), 32'd1);
    a_c.mem_resp = 1; a_c.mem_rdata = 32'hdeadbeef; #1;
    chk("t1_p0resp",  32'(a_p0.mem_resp), 32'd1);
    chk("t1_p0rdata", a_p0.mem_rdata, 32'hdeadbeef);
    chk("t1_p1resp",  32'(a_p1.mem_resp), 32'd0);
    tick();
    a_c.mem_resp = 0; a_p0.mem_read = 0;
    tick();

    // Stray resp while idle is not routed
    a_c.mem_resp = 1; #1;
    chk("stray_p0resp", 32'(a_p0.mem_resp), 32'd0);
    chk("stray_p1resp", 32'(a_p1.mem_resp), 32'd0);
    tick();
    a_c.mem_resp = 0;
    chk("stray_grant", 32'(a_grant), 32'd0);

    // p1 changes its address mid-transaction
    a_p1.mem_read = 1; a_p1.mem_address = 32'h40;
    tick();
    chk("t6_addr_a", a_c.mem_address, 32'h40);
    a_p1.mem_address = 32'h80;
    tick();
    chk("t6_addr_b", a_c.mem_address, 32'h40);
    tick();
    chk("t6_addr_c", a_c.mem_address, 32'h40);
    a_c.mem_resp = 1; #1;
    chk("t6_p1resp", 32'(a_p1.mem_resp), 32'd1);
    chk("t6_p0resp", 32'(a_p0.mem_resp), 32'd0);
    tick();
    a_c.mem_resp = 0; a_p1.mem_read = 0;
    tick();

    // Watchdog: cache holds resp back for 12 GNT cycles
    a_p0.mem_read = 1; a_p0.mem_address = 32'h500;
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("t4_tout_before", 32'(a_tout), 32'd0);
    tick();
    chk("t4_tout_set", 32'(a_tout), 32'd1);
    chk("t4_still_gnt", 32'(a_grant), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    a_c.mem_resp = 1; #1;
    chk("t4_p0resp", 32'(a_p0.mem_resp), 32'd1);
    tick();
    a_c.mem_resp = 0; a_p0.mem_read = 0;
    chk("t4_tout_sticky", 32'(a_tout), 32'd1);
    tick();

    // Asynchronous reset in the middle of GNT1
    a_p1.mem_write = 1; a_p1.mem_address = 32'h600;
    tick();
    chk("t5_write_pre", 32'(a_c.mem_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_write_rst", 32'(a_c.mem_write), 32'd0);
    chk("t5_grant_rst", 32'(a_grant), 32'd0);
    chk("t5_tout_rst",  32'(a_tout), 32'd0);
    tick();
    clear_inputs();
    #2 rst_n = 1'b1;
    a_p0.mem_read = 1; a_p0.mem_address = 32'h700;
    a_p1.mem_read = 1; a_p1.mem_address = 32'h800;
    tick();
    chk("t5_tie_grant", 32'(a_grant), 32'd1);
    chk("t5_tie_addr",  a_c.mem_address, 32'h700);
    a_c.mem_resp = 1;
    tick();
    a_c.mem_resp = 0; a_p0.mem_read = 0; a_p1.mem_read = 0;
    tick();

    // Fixed priority: p1 keeps requesting and wins every tie
    b_p0.mem_read = 1; b_p0.mem_address = 32'h10;
    b_p1.mem_read = 1; b_p1.mem_address = 32'h20;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_grant_p1", 32'(b_grant), 32'd2);
      chk("t3_addr_p1",  b_c.mem_address, 32'h20 + 32'(i) * 32'h4);
      b_c.mem_resp = 1; #1;
      chk("t3_p0resp", 32'(b_p0.mem_resp), 32'd0);
      tick();
      b_c.mem_resp = 0;
      b_p1.mem_address = 32'h24 + 32'(i) * 32'h4;
      if (i == 2) b_p1.mem_read = 0;
      tick();
    end
    tick();
    chk("t3_grant_p0", 32'(b_grant), 32'd1);
    chk("t3_addr_p0",  b_c.mem_address, 32'h10);
    chk("t3_tout_off", 32'(b_tout), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
